// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package intc_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  // CSR addresses (waddr also selects the combinational read view)
  localparam logic [1:0] CSR_MASK  = 2'd0;
  localparam logic [1:0] CSR_PEND  = 2'd1;
  localparam logic [1:0] CSR_INSRV = 2'd2;
  localparam logic [1:0] CSR_ID    = 2'd3;

  // Handler address for a source index
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [4:0] idx);
    return base + 32'(idx) * stride;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-set-bit priority encoder: index 0 wins.
module intc_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  localparam int unsigned W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = W'(i);
    end
  end

endmodule

// File: rtl/intc_vectored.sv
// Vectored interrupt controller: latches, masks and prioritises NSRC request lines, drives the
// CPU intr/inta handshake, supplies id/vector and tracks in-service sources until eoi.
// Optional build macro INTC_NESTING_EN enables preemption by strictly higher-priority sources.
module intc_vectored
  import intc_pkg::*;
#(
  parameter int unsigned     NSRC       = 8,
  parameter logic [NSRC-1:0] EDGE_MASK  = {NSRC{1'b1}},
  parameter logic [31:0]     VEC_BASE   = 32'h0000_0008,
  parameter logic [31:0]     VEC_STRIDE = 32'h0000_0010
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NSRC-1:0]         irq,
  input  logic                    inta,
  input  logic                    eoi,
  input  logic                    we,
  input  logic [1:0]              waddr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    intr,
  output logic [$clog2(NSRC)-1:0] id,
  output logic [31:0]             vec
);

  localparam int unsigned IW = $clog2(NSRC);

  state_e          state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] inserv_q, inserv_d;
  logic [NSRC-1:0] irq_q;
  logic            intr_q, intr_d;
  logic [IW-1:0]   id_q, id_d;

  logic            cand_valid;
  logic [IW-1:0]   cand_idx;
  logic            insv_valid;
  logic [IW-1:0]   insv_idx;

  logic            acc_inta;
  logic            acc_eoi;
  logic [NSRC-1:0] inta_set;
  logic [NSRC-1:0] eoi_clr;
  logic [NSRC-1:0] w1c;

  // Only wdata[NSRC-1:0] carries register bits
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  intc_prio_enc #(
    .N(NSRC)
  ) u_cand_enc (
    .req  (pend_q & ~mask_q),
    .valid(cand_valid),
    .index(cand_idx)
  );

  intc_prio_enc #(
    .N(NSRC)
  ) u_insv_enc (
    .req  (inserv_q),
    .valid(insv_valid),
    .index(insv_idx)
  );

  // Handshake qualification and the bit masks derived from it
  always_comb begin
    acc_inta = (state_q == REQ) && inta;
`ifdef INTC_NESTING_EN
    acc_eoi  = ((state_q == SERV) || (state_q == REQ)) && eoi && insv_valid;
`else
    acc_eoi  = (state_q == SERV) && eoi && insv_valid;
`endif
    inta_set = acc_inta ? (NSRC'(1) << id_q) : '0;
    eoi_clr  = acc_eoi ? (NSRC'(1) << insv_idx) : '0;
    w1c      = (we && (waddr == CSR_PEND)) ? wdata[NSRC-1:0] : '0;
  end

  // Mask, pending and in-service next state
  always_comb begin
    mask_d = mask_q;
    if (we && (waddr == CSR_MASK)) mask_d = wdata[NSRC-1:0];
    pend_d = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE_MASK[i]) begin
        // A new edge on the same cycle as a clear keeps the request
        pend_d[i] = (irq[i] & ~irq_q[i]) | (pend_q[i] & ~(w1c[i] | inta_set[i]));
      end else begin
        pend_d[i] = irq[i];
      end
    end
    inserv_d = (inserv_q & ~eoi_clr) | inta_set;
  end

  // Request/acknowledge FSM; id and intr only change on REQ entry/exit
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d = REQ;
          id_d    = cand_idx;
          intr_d  = 1'b1;
        end
      end
      REQ: begin
        if (inta) begin
          state_d = SERV;
          intr_d  = 1'b0;
        end
      end
      SERV: begin
`ifdef INTC_NESTING_EN
        if (cand_valid && insv_valid && (cand_idx < insv_idx)) begin
          state_d = REQ;
          id_d    = cand_idx;
          intr_d  = 1'b1;
        end else if (inserv_d == '0) begin
          state_d = IDLE;
        end
`else
        if (inserv_d == '0) state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        intr_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      mask_q   <= '1;
      pend_q   <= '0;
      inserv_q <= '0;
      irq_q    <= '0;
      intr_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      inserv_q <= inserv_d;
      irq_q    <= irq;
      intr_q   <= intr_d;
      id_q     <= id_d;
    end
  end

  // CSR read view selected by waddr
  always_comb begin
    rdata = '0;
    case (waddr)
      CSR_MASK:  rdata = 32'(mask_q);
      CSR_PEND:  rdata = 32'(pend_q);
      CSR_INSRV: rdata = 32'(inserv_q);
      CSR_ID:    rdata = 32'(id_q);
      default:   rdata = '0;
    endcase
  end

  assign intr = intr_q;
  assign id   = id_q;
  assign vec  = vec_addr(VEC_BASE, VEC_STRIDE, 5'(id_q));

endmodule

// File: tb/tb_intc_vectored.sv
// Directed, table-driven bench for intc_vectored (NSRC=8, source 1 level-sensitive).
module tb_intc_vectored;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  irq = '0;
  logic        inta = 1'b0;
  logic        eoi = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        intr;
  logic [2:0]  id;
  logic [31:0] vec;

  int checks = 0;
  int errors = 0;

  intc_vectored #(
    .NSRC      (8),
    .EDGE_MASK (8'hFD),
    .VEC_BASE  (32'h0000_0008),
    .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .irq  (irq),
    .inta (inta),
    .eoi  (eoi),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .rdata(rdata),
    .intr (intr),
    .id   (id),
    .vec  (vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [7:0]  ir;
    logic        ia;
    logic        eo;
    logic        w;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic        ei;
    logic [2:0]  eid;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic [7:0] ir, input logic ia, input logic eo,
                     input logic w, input logic [1:0] wa, input logic [31:0] wd,
                     input logic [1:0] ra, input logic ei, input logic [2:0] eid,
                     input logic [31:0] er);
    vec_t v;
    v.c = c; v.ir = ir; v.ia = ia; v.eo = eo; v.w = w; v.wa = wa; v.wd = wd;
    v.ra = ra; v.ei = ei; v.eid = eid; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, drop strobes, then select the read address
  task automatic step(input logic c, input logic [7:0] ir, input logic ia, input logic eo,
                      input logic w, input logic [1:0] wa, input logic [31:0] wd,
                      input logic [1:0] ra);
    clr = c; irq = ir; inta = ia; eoi = eo; we = w; waddr = wa; wdata = wd;
    @(posedge clk);
    #1;
    clr = 1'b0; inta = 1'b0; eoi = 1'b0; we = 1'b0; waddr = ra;
    #1;
  endtask

  task automatic check_out(input string tag, input logic ei, input logic [2:0] eid,
                           input logic [31:0] er);
    chk({tag, "_intr"}, 32'(intr), 32'(ei));
    chk({tag, "_id"}, 32'(id), 32'(eid));
    chk({tag, "_vec"}, vec, 32'h8 + 32'(eid) * 32'h10);
    chk({tag, "_rdata"}, rdata, er);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //  c  irq    ia eo w  wa wd     ra   intr id rdata
    add(1, 8'h00, 0, 0, 0, 0, 32'h0,  0,   0, 0, 32'hFF);  // reset: mask all 1
    add(1, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 0, 32'h00);  // reset: pending 0
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  2,   0, 0, 32'h00);  // reset: inserv 0
    // single edge request on source 3
    add(0, 8'h00, 0, 0, 1, 0, 32'h0,  0,   0, 0, 32'h00);
    add(0, 8'h08, 0, 0, 0, 0, 32'h0,  1,   0, 0, 32'h08);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   1, 3, 32'h08);
    add(0, 8'h00, 1, 0, 0, 0, 32'h0,  2,   0, 3, 32'h08);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 3, 32'h00);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  2,   0, 3, 32'h00);
    // simultaneous sources 5 and 2
    add(0, 8'h24, 0, 0, 0, 0, 32'h0,  1,   0, 3, 32'h24);
    add(0, 8'h24, 0, 0, 0, 0, 32'h0,  3,   1, 2, 32'h02);
    add(0, 8'h00, 1, 0, 0, 0, 32'h0,  1,   0, 2, 32'h20);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  2,   0, 2, 32'h00);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  3,   1, 5, 32'h05);
    add(0, 8'h00, 1, 0, 0, 0, 32'h0,  2,   0, 5, 32'h20);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  1,   0, 5, 32'h00);
    // level source 1
    add(0, 8'h02, 0, 0, 0, 0, 32'h0,  1,   0, 5, 32'h02);
    add(0, 8'h02, 0, 0, 0, 0, 32'h0,  3,   1, 1, 32'h01);
    add(0, 8'h02, 1, 0, 0, 0, 32'h0,  2,   0, 1, 32'h02);
    add(0, 8'h02, 0, 1, 0, 0, 32'h0,  2,   0, 1, 32'h00);
    add(0, 8'h02, 0, 0, 0, 0, 32'h0,  1,   1, 1, 32'h02);
    add(0, 8'h02, 1, 0, 0, 0, 32'h0,  2,   0, 1, 32'h02);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h00);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  2,   0, 1, 32'h00);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h00);
    // masking and unmask
    add(0, 8'h00, 0, 0, 1, 0, 32'hFF, 0,   0, 1, 32'hFF);
    add(0, 8'h01, 0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h01);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h01);
    add(0, 8'h00, 0, 0, 1, 0, 32'h0,  0,   0, 1, 32'h00);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  3,   1, 0, 32'h00);
    add(0, 8'h00, 1, 0, 0, 0, 32'h0,  2,   0, 0, 32'h01);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  2,   0, 0, 32'h00);
    // W1C while masked, then set-beats-clear
    add(0, 8'h00, 0, 0, 1, 0, 32'hFF, 0,   0, 0, 32'hFF);
    add(0, 8'h01, 0, 0, 0, 0, 32'h0,  1,   0, 0, 32'h01);
    add(0, 8'h00, 0, 0, 1, 1, 32'h01, 1,   0, 0, 32'h00);
    add(0, 8'h00, 0, 0, 1, 0, 32'h0,  1,   0, 0, 32'h00);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  1,   0, 0, 32'h00);
    add(0, 8'h01, 0, 0, 1, 1, 32'h01, 1,   0, 0, 32'h01);
    add(0, 8'h01, 0, 0, 0, 0, 32'h0,  3,   1, 0, 32'h00);
    // clr while REQ, ignored inta/eoi/read-only writes
    add(1, 8'h01, 1, 0, 0, 0, 32'h0,  0,   0, 0, 32'hFF);
    add(0, 8'h01, 1, 0, 0, 0, 32'h0,  1,   0, 0, 32'h01);
    add(0, 8'h00, 0, 0, 0, 0, 32'h0,  2,   0, 0, 32'h00);
    add(0, 8'h00, 0, 0, 1, 2, 32'hFF, 2,   0, 0, 32'h00);
    add(0, 8'h00, 0, 0, 1, 3, 32'h0,  0,   0, 0, 32'hFF);
    add(0, 8'h00, 0, 1, 0, 0, 32'h0,  2,   0, 0, 32'h00);
    add(0, 8'h00, 0, 0, 1, 1, 32'hFF, 1,   0, 0, 32'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].ir, tbl[i].ia, tbl[i].eo, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ra);
      check_out($sformatf("v%0d", i), tbl[i].ei, tbl[i].eid, tbl[i].er);
    end

    // Higher-priority request arriving while source 4 is in service
    step(0, 8'h00, 0, 0, 1, 0, 32'h0, 0);
    check_out("n_unmask", 0, 0, 32'h00);
    step(0, 8'h10, 0, 0, 0, 0, 32'h0, 1);
    check_out("n_pend4", 0, 0, 32'h10);
    step(0, 8'h00, 0, 0, 0, 0, 32'h0, 3);
    check_out("n_req4", 1, 4, 32'h04);
    step(0, 8'h00, 1, 0, 0, 0, 32'h0, 2);
    check_out("n_serv4", 0, 4, 32'h10);
    step(0, 8'h02, 0, 0, 0, 0, 32'h0, 1);
    check_out("n_pend1", 0, 4, 32'h02);
`ifdef INTC_NESTING_EN
    step(0, 8'h02, 0, 0, 0, 0, 32'h0, 3);
    check_out("n_preempt", 1, 1, 32'h01);
    step(0, 8'h00, 1, 0, 0, 0, 32'h0, 2);
    check_out("n_insv12", 0, 1, 32'h12);
    step(0, 8'h00, 0, 1, 0, 0, 32'h0, 2);
    check_out("n_eoi1", 0, 1, 32'h10);
    step(0, 8'h00, 0, 1, 0, 0, 32'h0, 2);
    check_out("n_eoi4", 0, 1, 32'h00);
    step(0, 8'h00, 0, 0, 0, 0, 32'h0, 1);
    check_out("n_idle", 0, 1, 32'h00);
`else
    step(0, 8'h02, 0, 0, 0, 0, 32'h0, 3);
    check_out("n_hold", 0, 4, 32'h04);
    step(0, 8'h02, 1, 0, 0, 0, 32'h0, 2);
    check_out("n_inta_ign", 0, 4, 32'h10);
    step(0, 8'h02, 0, 1, 0, 0, 32'h0, 2);
    check_out("n_eoi4", 0, 4, 32'h00);
    step(0, 8'h02, 0, 0, 0, 0, 32'h0, 3);
    check_out("n_req1", 1, 1, 32'h01);
    step(0, 8'h00, 1, 0, 0, 0, 32'h0, 2);
    check_out("n_serv1", 0, 1, 32'h02);
    step(0, 8'h00, 0, 1, 0, 0, 32'h0, 2);
    check_out("n_eoi1", 0, 1, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
